// File: rtl/aes_sub_shift_iter_pkg.sv
// aes_sub_shift_iter_pkg: shared cipher-direction enum, FSM states and state byte-index helpers
package aes_sub_shift_iter_pkg;

    typedef enum logic {
        CIPH_FWD = 1'b0,
        CIPH_INV = 1'b1
    } ciph_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SUB,
        ST_DONE
    } fsm_e;

    // Row-major layout: byte (r, c) lives at data[8*(4r+c) +: 8]
    function automatic int byte_idx(input int r, input int c);
        return 4 * r + c;
    endfunction

    function automatic int idx_row(input int i);
        return i / 4;
    endfunction

    function automatic int idx_col(input int i);
        return i % 4;
    endfunction

endpackage

// File: rtl/aes_sub_shift_iter_sbox.sv
// aes_sbox: combinational AES S-box / inverse S-box
//   op_i   : CIPH_FWD = S(x), CIPH_INV = S^-1(x)
//   data_i : input byte
//   data_o : substituted byte
module aes_sbox
    import aes_sub_shift_iter_pkg::*;
(
    input  ciph_op_e   op_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 = a^2 * a^4 * ... * a^128; maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    logic [7:0] fwd_inv;
    logic [7:0] inv_aff;

    always_comb begin
        fwd_inv = gf_inv(data_i);
        inv_aff = {data_i[6:0], data_i[7]} ^ {data_i[4:0], data_i[7:5]} ^ {data_i[1:0], data_i[7:2]} ^ 8'h05;
        data_o  = (op_i == CIPH_INV) ? gf_inv(inv_aff)
                : fwd_inv ^ {fwd_inv[6:0], fwd_inv[7]} ^ {fwd_inv[5:0], fwd_inv[7:6]}
                  ^ {fwd_inv[4:0], fwd_inv[7:5]} ^ {fwd_inv[3:0], fwd_inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/aes_sub_shift_iter.sv
// aes_sub_shift_iter: iterative SubBytes+ShiftRows (fwd/inv), SBOX_PER_CYCLE bytes per clock
//   clk_i/rst_i/clear_i     : clock, sync active-high reset, sync abort (same effect as reset)
//   op_i                    : 0 fwd, 1 inv; sampled on accept
//   in_valid_i/in_ready_o   : input handshake, data_i 128-bit state
//   out_valid_o/out_ready_i : output handshake, data_o 128-bit state
module aes_sub_shift_iter
    import aes_sub_shift_iter_pkg::*;
#(
    parameter int SBOX_PER_CYCLE = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         op_i,
    input  logic         in_valid_i,
    output logic         in_ready_o,
    input  logic [127:0] data_i,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic [127:0] data_o
);

    localparam int NG = 16 / SBOX_PER_CYCLE;
    localparam int GW = (NG > 1) ? $clog2(NG) : 1;
    localparam int SW = 8 * SBOX_PER_CYCLE;

    fsm_e          state_q;
    fsm_e          state_d;
    logic [GW-1:0] grp_q;
    logic [127:0]  st_q;
    ciph_op_e      op_q;
    logic [SW-1:0] sb_in;
    logic [SW-1:0] sb_out;
    logic          last_grp;

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input ciph_op_e op);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[8*byte_idx(r, c) +: 8] = s[8*byte_idx(r, (op == CIPH_INV) ? (c - r + 4) % 4 : (c + r) % 4) +: 8];
        return o;
    endfunction

    for (genvar i = 0; i < SBOX_PER_CYCLE; i++) begin : g_sbox
        aes_sbox u_sbox (
            .op_i  (op_q),
            .data_i(sb_in[8*i +: 8]),
            .data_o(sb_out[8*i +: 8])
        );
    end

    always_comb begin
        last_grp    = grp_q == GW'(NG - 1);
        sb_in       = st_q[int'(grp_q)*SW +: SW];
        in_ready_o  = state_q == ST_IDLE;
        out_valid_o = state_q == ST_DONE;
        data_o      = shift_rows(st_q, op_q);
        state_d     = (state_q == ST_IDLE && in_valid_i)  ? ST_SUB
                    : (state_q == ST_SUB  && last_grp)    ? ST_DONE
                    : (state_q == ST_DONE && out_ready_i) ? ST_IDLE
                    : state_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q <= ST_IDLE;
            grp_q   <= '0;
            st_q    <= '0;
            op_q    <= CIPH_FWD;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && in_valid_i) begin
                st_q  <= data_i;
                op_q  <= ciph_op_e'(op_i);
                grp_q <= '0;
            end else if (state_q == ST_SUB) begin
                st_q[int'(grp_q)*SW +: SW] <= sb_out;
                grp_q <= last_grp ? '0 : grp_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_aes_sub_shift_iter.sv
// tb_aes_sub_shift_iter: directed checks of the iterative SubBytes+ShiftRows stage for N = 4, 8, 16
module tb_aes_sub_shift_iter;

    logic         clk = 1'b0;
    logic [2:0]   rst_v;
    logic [2:0]   clr_v;
    logic         op_i;
    logic         in_valid;
    logic [2:0]   in_ready;
    logic [127:0] data_i;
    logic [2:0]   out_valid;
    logic         out_ready;
    logic [127:0] dout [3];

    logic [127:0] res [3];
    int           lat [3];
    int           errors = 0;
    int           checks = 0;
    logic [127:0] seq;

    logic [7:0] fsb [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };
    logic [7:0] isb [256];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_sub_shift_iter #(.SBOX_PER_CYCLE(4 << g)) u_dut (
            .clk_i      (clk),
            .rst_i      (rst_v[g]),
            .clear_i    (clr_v[g]),
            .op_i       (op_i),
            .in_valid_i (in_valid),
            .in_ready_o (in_ready[g]),
            .data_i     (data_i),
            .out_valid_o(out_valid[g]),
            .out_ready_i(out_ready),
            .data_o     (dout[g])
        );
    end

    always #5 clk = ~clk;

    function automatic int ng(input int k);
        return 16 / (4 << k);
    endfunction

    function automatic logic [127:0] model(input logic op, input logic [127:0] d);
        logic [127:0] o;
        o = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                automatic int src = op ? (c + 4 - r) % 4 : (c + r) % 4;
                automatic logic [7:0] b = d[8*(4*r+src) +: 8];
                o[8*(4*r+c) +: 8] = op ? isb[b] : fsb[b];
            end
        return o;
    endfunction

    // One transaction on all three DUTs; inputs are scrambled right after the accept edge
    task automatic run(input logic op, input logic [127:0] d);
        int beats [3];
        @(negedge clk);
        op_i = op; data_i = d; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin lat[k] = -1; beats[k] = 0; res[k] = 'x; end
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0; op_i = ~op; data_i = ~d;
            for (int k = 0; k < 3; k++)
                if (out_valid[k]) begin
                    beats[k]++;
                    if (lat[k] < 0) begin lat[k] = cyc; res[k] = dout[k]; end
                end
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (lat[k] !== ng(k) + 1 || beats[k] !== 1) begin
                errors++;
                $display("FAIL handshake dut%0d: latency=%0d beats=%0d, required latency=%0d beats=1", k, lat[k], beats[k], ng(k) + 1);
            end
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready[k] !== 1'b1 || out_valid[k] !== 1'b0 || dout[k] !== '0) begin
                errors++;
                $display("FAIL reset dut%0d: in_ready=%b out_valid=%b data_o=%h, required 1 0 0", k, in_ready[k], out_valid[k], dout[k]);
            end
        end
    endtask

    task automatic test_fwd_zero();
        run(1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res[k] !== {16{8'h63}}) begin
                errors++;
                $display("FAIL fwd_zero dut%0d: got %h, required %h", k, res[k], {16{8'h63}});
            end
        end
    endtask

    task automatic test_fwd_seq();
        run(1'b0, seq);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res[k][63:0] !== 64'hf2c56f6b_7b777c63) begin
                errors++;
                $display("FAIL fwd_seq_rows01 dut%0d: got %h, required %h", k, res[k][63:0], 64'hf2c56f6b_7b777c63);
            end
            checks++;
            if (res[k] !== model(1'b0, seq)) begin
                errors++;
                $display("FAIL fwd_seq dut%0d: got %h, required %h", k, res[k], model(1'b0, seq));
            end
        end
    endtask

    task automatic test_inv();
        logic [127:0] f;
        run(1'b1, {16{8'h63}});
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res[k] !== '0) begin
                errors++;
                $display("FAIL inv_63 dut%0d: got %h, required 0", k, res[k]);
            end
        end
        f = model(1'b0, 128'h3243f6a8_885a308d_313198a2_e0370734);
        run(1'b1, f);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res[k] !== 128'h3243f6a8_885a308d_313198a2_e0370734) begin
                errors++;
                $display("FAIL inv_roundtrip dut%0d: got %h, required %h", k, res[k], 128'h3243f6a8_885a308d_313198a2_e0370734);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 100; n++) begin
            automatic logic op = 1'($urandom_range(0, 1));
            automatic logic [127:0] d = {$urandom, $urandom, $urandom, $urandom};
            run(op, d);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (res[k] !== model(op, d)) begin
                    errors++;
                    $display("FAIL random dut%0d op=%b in=%h: got %h, required %h", k, op, d, res[k], model(op, d));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [127:0] held [3];
        out_ready = 1'b0;
        @(negedge clk);
        op_i = 1'b0; data_i = seq; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 0; cyc < 20 && out_valid !== 3'b111; cyc++) @(negedge clk);
        checks++;
        if (out_valid !== 3'b111) begin
            errors++;
            $display("FAIL bp_timeout: out_valid=%b, required 111", out_valid);
        end
        for (int k = 0; k < 3; k++) held[k] = dout[k];
        in_valid = 1'b1; data_i = '1;
        repeat (10) begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0 || dout[k] !== held[k]) begin
                    errors++;
                    $display("FAIL bp_hold dut%0d: out_valid=%b in_ready=%b data_o=%h, required 1 0 %h", k, out_valid[k], in_ready[k], dout[k], held[k]);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || held[k] !== model(1'b0, seq)) begin
                errors++;
                $display("FAIL bp_release dut%0d: out_valid=%b in_ready=%b held=%h, required 0 1 %h", k, out_valid[k], in_ready[k], held[k], model(1'b0, seq));
            end
        end
    endtask

    // Abort lands on group 2 for N=4, the last group for N=8, group 0 for N=16
    task automatic test_abort(input bit use_clear);
        @(negedge clk);
        op_i = 1'b0; data_i = seq; in_valid = 1'b1;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            in_valid = 1'b0;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (out_valid[k] !== 1'b0) begin
                    errors++;
                    $display("FAIL abort_no_valid dut%0d clear=%0d cyc=%0d: out_valid=%b, required 0", k, use_clear, cyc, out_valid[k]);
                end
                if (cyc == 4 - k) begin
                    rst_v[k] = 1'b0; clr_v[k] = 1'b0;
                    checks++;
                    if (in_ready[k] !== 1'b1 || dout[k] !== '0) begin
                        errors++;
                        $display("FAIL abort_idle dut%0d clear=%0d: in_ready=%b data_o=%h, required 1 0", k, use_clear, in_ready[k], dout[k]);
                    end
                end
                if (cyc == 3 - k) begin
                    if (use_clear) clr_v[k] = 1'b1;
                    else rst_v[k] = 1'b1;
                end
            end
        end
        if (use_clear) begin
            clr_v = 3'b111; in_valid = 1'b1; data_i = seq;
            @(negedge clk);
            clr_v = 3'b000; in_valid = 1'b0;
            repeat (6) begin
                @(negedge clk);
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1 || dout[k] !== '0) begin
                        errors++;
                        $display("FAIL clear_wins dut%0d: out_valid=%b in_ready=%b data_o=%h, required 0 1 0", k, out_valid[k], in_ready[k], dout[k]);
                    end
                end
            end
        end
        run(1'b0, seq);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res[k] !== model(1'b0, seq)) begin
                errors++;
                $display("FAIL abort_recover dut%0d clear=%0d: got %h, required %h", k, use_clear, res[k], model(1'b0, seq));
            end
        end
    endtask

    task automatic test_mid_change();
        run(1'b1, 128'h00112233_44556677_8899aabb_ccddeeff);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (res[k] !== model(1'b1, 128'h00112233_44556677_8899aabb_ccddeeff)) begin
                errors++;
                $display("FAIL mid_change dut%0d: got %h, required %h", k, res[k], model(1'b1, 128'h00112233_44556677_8899aabb_ccddeeff));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) isb[fsb[i]] = 8'(i);
        for (int i = 0; i < 16; i++) seq[8*i +: 8] = 8'(i);
        rst_v = 3'b111; clr_v = 3'b000; op_i = 1'b0; in_valid = 1'b0; data_i = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_v = 3'b000;
        @(negedge clk);
        test_reset();
        test_fwd_zero();
        test_fwd_seq();
        test_inv();
        test_backpressure();
        test_abort(1'b0);
        test_abort(1'b1);
        test_mid_change();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
